// File: rtl/serial_to_parallel_converter_pkg.sv
// ============================================================================
// Module : serial_to_parallel_converter_pkg
// Brief  : Types shared by parallel_to_serial_converter and serial_to_parallel_converter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_to_parallel_converter_pkg;

  typedef enum logic {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } shift_direction_t_;

  // Counter width that still works for the smallest legal word (N = 2).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_to_parallel_converter_collector.sv
// ============================================================================
// Module : serial_shift_collector
// Brief  : Bit counter, shift register and per-word direction latch.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_shift_collector
  import serial_to_parallel_converter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              bit_i,
  input  shift_direction_t_ direction_i,
  output logic [N-1:0]      word_o,
  output logic              word_done_o,
  output logic              busy_o
);

  localparam int CW = cnt_width(N);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N-1:0]      shift_q, shift_d;
  shift_direction_t_ dir_q, dir_d;
  shift_direction_t_ dir_eff;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    dir_d       = dir_q;
    word_done_o = 1'b0;
    // The first bit of a word uses the live input; later bits use the latch.
    dir_eff     = (state_q == S_IDLE) ? direction_i : dir_q;
    if (valid_i) begin
      if (state_q == S_IDLE) begin
        dir_d = direction_i;
      end
      if (dir_eff == MSB_FIRST) begin
        shift_d = {shift_q[N-2:0], bit_i};
      end else begin
        shift_d = {bit_i, shift_q[N-1:1]};
      end
      if (cnt_q == CW'(N - 1)) begin
        cnt_d       = '0;
        state_d     = S_IDLE;
        word_done_o = 1'b1;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = S_SHIFT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      dir_q   <= MSB_FIRST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state word so the holding register captures the N-th bit on its own edge.
  assign word_o = shift_d;
  assign busy_o = (state_q == S_SHIFT);

endmodule

`default_nettype wire

// File: rtl/serial_to_parallel_converter.sv
// ============================================================================
// Module : serial_to_parallel_converter
// Brief  : Serial-to-word deserialiser with a one-word valid/ready holding register.
//          Optional macro S2P_OVERRUN_DETECT_EN: drop new word and flag overrun.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_to_parallel_converter
  import serial_to_parallel_converter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_bit,
  input  shift_direction_t_ direction,
  input  logic              o_ready,
  output logic              o_valid,
  output logic [N-1:0]      o_data,
  output logic              o_busy,
  output logic              o_overrun
);

  logic [N-1:0] word;
  logic         word_done;
  logic         valid_q, valid_d;
  logic [N-1:0] data_q, data_d;
`ifdef S2P_OVERRUN_DETECT_EN
  logic         overrun_q, overrun_d;
`endif

  serial_shift_collector #(
    .N (N)
  ) u_collector (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (i_valid),
    .bit_i       (i_bit),
    .direction_i (direction),
    .word_o      (word),
    .word_done_o (word_done),
    .busy_o      (o_busy)
  );

  always_comb begin
    valid_d = valid_q & ~o_ready;
    data_d  = data_q;
`ifdef S2P_OVERRUN_DETECT_EN
    overrun_d = 1'b0;
    if (word_done) begin
      if (valid_q && !o_ready) begin
        overrun_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        data_d  = word;
      end
    end
`else
    // Without detection the newest word always wins.
    if (word_done) begin
      valid_d = 1'b1;
      data_d  = word;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
`ifdef S2P_OVERRUN_DETECT_EN
      overrun_q <= 1'b0;
`endif
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
`ifdef S2P_OVERRUN_DETECT_EN
      overrun_q <= overrun_d;
`endif
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
`ifdef S2P_OVERRUN_DETECT_EN
  assign o_overrun = overrun_q;
`else
  assign o_overrun = 1'b0;
`endif

endmodule

`default_nettype wire
